// File: rtl/pacman_pkg.sv
// Shared types and helpers for the Pac-Man life/state controller.
package pacman_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READY,
        ST_PLAY,
        ST_DYING,
        ST_GAMEOVER
    } life_state_t;

    localparam int unsigned LIVES_MAX = 2;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Index of the final tick of an N-tick hold; a zero-length hold behaves as one tick.
    function automatic int unsigned last_frame(input int unsigned n);
        return (n == 0) ? 0 : n - 1;
    endfunction

    // Simultaneous award and loss cancel; otherwise saturate at 0 and LIVES_MAX.
    function automatic logic [1:0] lives_adjust(input logic [1:0] cur,
                                                input logic       inc,
                                                input logic       dec);
        logic [1:0] nxt;
        nxt = cur;
        if (inc && !dec) begin
            if (cur < 2'(LIVES_MAX)) nxt = cur + 2'd1;
        end else if (dec && !inc) begin
            if (cur != 2'd0) nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Registered rising-edge detector turning the vsync level into a one-Clk frame tick.
module frame_tick_gen (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk,
    output logic tick
);

    logic frame_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_q <= 1'b0;
            tick    <= 1'b0;
        end else begin
            frame_q <= frame_clk;
            tick    <= frame_clk & ~frame_q;
        end
    end

endmodule

// File: rtl/pacman_life_ctrl.sv
// Game life/state sequencer: IDLE -> READY -> PLAY -> DYING -> READY/GAMEOVER.
// Define PACMAN_EXTRA_LIFE_EN to enable the once-per-game score bonus life.
module pacman_life_ctrl
    import pacman_pkg::*;
#(
    parameter int unsigned START_LIVES      = 2,
    parameter int unsigned DEATH_FRAMES     = 120,
    parameter int unsigned READY_FRAMES     = 60,
    parameter int unsigned GAMEOVER_FRAMES  = 180,
    parameter int unsigned EXTRA_LIFE_SCORE = 10000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic        start_game,
    input  logic        pacman_caught,
    input  logic [15:0] score,
    output logic [1:0]  lives,
    output logic        play_en,
    output logic        dying,
    output logic        ready_hold,
    output logic        respawn,
    output logic        game_over
);

    localparam int unsigned FRAME_MAX = max3(DEATH_FRAMES, READY_FRAMES, GAMEOVER_FRAMES);
    localparam int unsigned CW        = $clog2(FRAME_MAX) + 1;

    localparam logic [CW-1:0] READY_LAST    = CW'(last_frame(READY_FRAMES));
    localparam logic [CW-1:0] DEATH_LAST    = CW'(last_frame(DEATH_FRAMES));
    localparam logic [CW-1:0] GAMEOVER_LAST = CW'(last_frame(GAMEOVER_FRAMES));
    localparam logic [1:0]    START_L       = (START_LIVES > LIVES_MAX) ? 2'(LIVES_MAX)
                                                                        : 2'(START_LIVES);

    life_state_t   state;
    logic [CW-1:0] cnt;
    logic          tick;
    logic          award;

    frame_tick_gen u_frame_tick_gen (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

`ifdef PACMAN_EXTRA_LIFE_EN
    logic bonus_q;

    assign award = !bonus_q
                && ((state == ST_PLAY) || (state == ST_DYING))
                && (32'(score) >= 32'(EXTRA_LIFE_SCORE));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bonus_q <= 1'b0;
        end else if ((state == ST_IDLE) && start_game) begin
            bonus_q <= 1'b0;
        end else if (award) begin
            bonus_q <= 1'b1;
        end
    end
`else
    logic unused_score;

    assign award        = 1'b0;
    assign unused_score = ^{score, 32'(EXTRA_LIFE_SCORE)};
`endif

    // Counter is cleared on every state entry, so a tick on the transition cycle never counts.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            lives      <= '0;
            play_en    <= 1'b0;
            dying      <= 1'b0;
            ready_hold <= 1'b0;
            respawn    <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            respawn <= 1'b0;
            lives   <= lives_adjust(lives, award, 1'b0);

            case (state)
                ST_IDLE: begin
                    if (start_game) begin
                        state      <= ST_READY;
                        cnt        <= '0;
                        lives      <= START_L;
                        ready_hold <= 1'b1;
                        respawn    <= 1'b1;
                    end
                end

                ST_READY: begin
                    if (tick) begin
                        if (cnt == READY_LAST) begin
                            state      <= ST_PLAY;
                            cnt        <= '0;
                            ready_hold <= 1'b0;
                            play_en    <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                ST_PLAY: begin
                    if (pacman_caught) begin
                        state   <= ST_DYING;
                        cnt     <= '0;
                        play_en <= 1'b0;
                        dying   <= 1'b1;
                    end
                end

                ST_DYING: begin
                    if (tick) begin
                        if (cnt == DEATH_LAST) begin
                            cnt   <= '0;
                            dying <= 1'b0;
                            if (lives != 2'd0) begin
                                state      <= ST_READY;
                                ready_hold <= 1'b1;
                                respawn    <= 1'b1;
                                lives      <= lives_adjust(lives, award, 1'b1);
                            end else begin
                                state     <= ST_GAMEOVER;
                                game_over <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                ST_GAMEOVER: begin
                    if (tick) begin
                        if (cnt == GAMEOVER_LAST) begin
                            state     <= ST_IDLE;
                            cnt       <= '0;
                            game_over <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state      <= ST_IDLE;
                    cnt        <= '0;
                    play_en    <= 1'b0;
                    dying      <= 1'b0;
                    ready_hold <= 1'b0;
                    game_over  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pacman_life_ctrl.md
PACMAN_LIFE_CTRL -- requirements
Module: pacman_life_ctrl

Interface
REQ-001 Parameter START_LIVES, default 2: reserve lives loaded at game start (range 0..2).
REQ-002 Parameter DEATH_FRAMES, default 120: frames the death animation holds play frozen.
REQ-003 Parameter READY_FRAMES, default 60: frames of "READY" hold before play resumes or starts.
REQ-004 Parameter GAMEOVER_FRAMES, default 180: frames the game-over screen holds before returning to idle.
REQ-005 Parameter EXTRA_LIFE_SCORE, default 10000: score threshold for the bonus life.
REQ-006 Clk  in  1  system clock; all state changes on rising edge.
REQ-007 Reset_n  in  1  asynchronous, active-low reset.
REQ-008 frame_clk  in  1  vertical-sync level signal; rising edge marks one frame.
REQ-009 start_game  in  1  level; request new game.
REQ-010 pacman_caught  in  1  single-Clk pulse; ghost collision.
REQ-011 score  in  16  current score, unsigned.
REQ-012 lives  out  2  reserve lives, 0..2; drives the lives display.
REQ-013 play_en  out  1  movement/ghost logic enabled.
REQ-014 dying  out  1  death animation active.
REQ-015 ready_hold  out  1  READY banner active.
REQ-016 respawn  out  1  single-Clk pulse: reset Pac-Man and ghosts to start positions.
REQ-017 game_over  out  1  game-over screen active.

Function
REQ-018 Frame tick SHALL be a one-Clk pulse, registered edge-detect of frame_clk; all frame counters advance only on tick.
REQ-019 States SHALL be IDLE, READY, PLAY, DYING, GAMEOVER; exactly one active.
REQ-020 IDLE: start_game=1 -> READY, lives<=START_LIVES, respawn pulses on the transition cycle.
REQ-021 READY: ready_hold=1; after READY_FRAMES ticks -> PLAY.
REQ-022 PLAY: play_en=1; pacman_caught -> DYING, frame counter cleared.
REQ-023 DYING: dying=1, play_en=0; after DEATH_FRAMES ticks: lives>0 -> READY, lives decremented, respawn pulse; lives==0 -> GAMEOVER, lives unchanged.
REQ-024 GAMEOVER: game_over=1; after GAMEOVER_FRAMES ticks -> IDLE.
REQ-025 pacman_caught outside PLAY SHALL be ignored.
REQ-026 lives SHALL never underflow below 0 nor exceed 2.
REQ-027 Frame counter width SHALL be $clog2 of the largest frame parameter plus 1; cleared on every state entry.
REQ-028 A tick coinciding with a state transition SHALL NOT count toward the new state.
REQ-029 Output latency: all outputs registered, valid one Clk after the causing edge.

Reset
REQ-030 Reset_n low SHALL immediately force IDLE, lives=0, all outputs 0, counters 0, bonus flag clear, edge-detect register 0.
REQ-031 Reset asserted mid-game SHALL abandon the game; no respawn pulse on release.

Configuration
REQ-032 Macro PACMAN_EXTRA_LIFE_EN defined: once per game, first Clk in PLAY or DYING with score>=EXTRA_LIFE_SCORE SHALL increment lives (saturating at 2) and set the bonus flag; flag cleared on IDLE->READY.
REQ-033 Award and the DYING-expiry decrement in the same cycle SHALL net to lives unchanged.
REQ-034 Macro undefined: no bonus logic, score input unused, lives only decrements.

Structure
REQ-035 Shared package pacman_pkg SHALL hold the life_state_t enum and LIVES_MAX=2 constant.
REQ-036 Sub-module frame_tick_gen SHALL implement frame_clk edge detection, reusable by ghost/animation logic.

Verification (bench uses DEATH_FRAMES=4, READY_FRAMES=2, GAMEOVER_FRAMES=3)
REQ-037 Start: start_game=1 -> respawn pulse, lives=2, ready_hold for 2 ticks, then play_en=1.
REQ-038 Three deaths: caught, 4 ticks -> lives 1; caught -> lives 0; caught, 4 ticks -> game_over=1 for 3 ticks, then IDLE, lives=0.
REQ-039 pacman_caught pulsed during READY and DYING -> no state or lives change.
REQ-040 With PACMAN_EXTRA_LIFE_EN, lives=1, score 9999->10000 -> lives=2; score 10500 later -> no further award.
REQ-041 With PACMAN_EXTRA_LIFE_EN, lives=1, score crosses 10000 on DYING-expiry cycle -> lives stays 1, state READY.
REQ-042 Reset_n low during DYING -> same-cycle IDLE, all outputs 0; release -> no respawn until start_game.
